instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Drives the instruction-fetch side of the IF/ID pipeline register.
- Owns the program counter and runs a req/ack handshake with instruction memory.
- Holds each fetched word in a one-entry buffer until the pipeline accepts it.
- Handles branch redirects from EXE, including discarding a memory response already in flight.
- Sits between instruction memory and the IF/ID register; its pc_out/instruction_out feed that register's pc_in/instruction_in.

## Interface
- ADDRESS_LEN, 32, width of addresses and instruction words (from configs)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall; buffer is not consumed while high
- branch_taken  in  1  single-cycle redirect pulse from EXE
- branch_address  in  ADDRESS_LEN  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  ADDRESS_LEN  fetch address
- imem_ack  in  1  response valid; may arrive in the request cycle or later
- imem_rdata  in  ADDRESS_LEN  instruction word, valid with imem_ack
- pc_out  out  ADDRESS_LEN  fetched address + 4; 0 when no valid instruction
- instruction_out  out  ADDRESS_LEN  fetched word; 0 (bubble) when no valid instruction
- fetch_valid  out  1  buffer holds a valid instruction

## Operation
- Registers:
  - pc: next fetch address, reset 0
  - buf_instr, buf_pc, buf_valid: reset 0
  - req_pending: reset 0
  - state: FETCH or KILL, reset FETCH
- Outputs are combinational from the buffer and are forced to 0 when buf_valid=0.
- Consume: the buffer is consumed at the clock edge when buf_valid && !freeze.
- Request issue (FETCH):
  - imem_req=1 when req_pending || !buf_valid || consume.
  - imem_addr=pc.
  - Once imem_req is asserted, both it and imem_addr stay stable until imem_ack; req_pending tracks this.
- Ack in FETCH:
  - buf_instr←imem_rdata, buf_pc←pc+4, buf_valid←1, pc←pc+4.
  - The buffer is always empty or being consumed at ack time.
- branch_taken, in any state, overrides everything:
  - pc←branch_address, buf_valid←0, regardless of freeze.
  - If a request is outstanding and imem_ack=0 this cycle, go to KILL.
  - If imem_ack=1 this cycle, the returned data is dropped and state stays FETCH.
- KILL:
  - imem_req stays high with the old address until ack.
  - The response is discarded, pc is unchanged, then go to FETCH.
  - A branch during KILL updates pc and stays in KILL. A branch together with an ack in KILL updates pc and goes to FETCH.
- PC arithmetic: pc+4 is modulo 2^ADDRESS_LEN, so 0xFFFFFFFC wraps to 0.
- Reset asserted mid-transaction clears all state immediately; imem_req drops asynchronously and any late ack is ignored.

## Timing
- Zero-wait memory (ack in the request cycle) gives one instruction per cycle.
- The word acked in cycle N is on instruction_out in cycle N+1.
- N-cycle memory latency gives N cycles of fetch_valid=0 per instruction.
- After a branch at cycle B, the first request to the target address issues:
  - in cycle B+1 if no request was outstanding;
  - in the cycle after the killed request's ack otherwise.
- freeze held for K cycles keeps the same instruction_out for K+1 cycles and issues no new request, except one that was already pending.

## Configuration
- FETCH_PERF_COUNTERS_EN defined:
  - Adds output stall_cycles (32 bits, reset 0).
  - Increments every cycle that fetch_valid=0.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Shared package/configs holds:
  - ADDRESS_LEN
  - FETCH/KILL state encodings
  - NOP constant (all zeros)
  - PC increment constant 4
- One sub-module, fetch_holding_buffer, contains:
  - buf_instr/buf_pc/buf_valid
  - load, consume and clear controls
  - zero-forcing of the outputs
- FSM, PC and handshake logic stay in the top module.

## Test plan
- Reset release, zero-wait memory returning 0xE3A01001 for address 0 → cycle after first ack: instruction_out=0xE3A01001, pc_out=4, fetch_valid=1.
- Memory with 3-cycle ack latency → fetch_valid low 3 of every 4 cycles, and imem_addr stable while req is pending.
- freeze high 2 cycles holding the instruction from address 8 → instruction_out unchanged 3 cycles, no new request, then address 12 fetched.
- Branch to 0x100 while a request to 0x20 is outstanding → KILL entered, 0x20 data never appears, next request address 0x100, and pc_out after its ack is 0x104.
- Branch in the same cycle as an ack → acked data dropped, no KILL, and the next cycle requests the target.
- pc=0xFFFFFFFC fetch → pc_out=0 and next request address 0; rst low mid-request → imem_req=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared configuration for the instruction fetch unit: widths, FSM
// encodings and the constants used by the fetch datapath.
package instruction_fetch_unit_pkg;

  localparam int ADDRESS_LEN = 32;

  // FETCH: normal operation. KILL: waiting to discard a stale response.
  typedef enum logic {
    FETCH = 1'b0,
    KILL  = 1'b1
  } fetch_state_t;

  localparam logic [ADDRESS_LEN-1:0] NOP     = '0;
  localparam logic [ADDRESS_LEN-1:0] PC_INCR = ADDRESS_LEN'(4);

endpackage

// File: rtl/instruction_fetch_unit_holding_buffer.sv
// One-entry buffer holding the fetched word and its pc+4 until the
// pipeline accepts it. Outputs read as a bubble (all zeros) when empty.
module fetch_holding_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   consume,
  input  logic                   clear,
  input  logic [ADDRESS_LEN-1:0] load_instr,
  input  logic [ADDRESS_LEN-1:0] load_pc,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic                   valid
);

  logic [ADDRESS_LEN-1:0] buf_instr;
  logic [ADDRESS_LEN-1:0] buf_pc;
  logic                   buf_valid;

  // Buffer update: a redirect clear beats a load, a load beats a consume.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_instr <= NOP;
      buf_pc    <= '0;
      buf_valid <= 1'b0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_instr <= load_instr;
      buf_pc    <= load_pc;
      buf_valid <= 1'b1;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

  // Stale data stays in the registers; the outputs hide it behind buf_valid.
  assign instruction_out = buf_valid ? buf_instr : NOP;
  assign pc_out          = buf_valid ? buf_pc    : '0;
  assign valid           = buf_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program counter, req/ack handshake with
// instruction memory, branch redirect with kill of an in-flight response.
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds the stall_cycles port.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_address,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic                   fetch_valid
);

  fetch_state_t           state, state_next;
  logic [ADDRESS_LEN-1:0] pc, pc_next;
  logic [ADDRESS_LEN-1:0] req_addr, req_addr_next;
  logic                   req_pending, req_pending_next;
  logic                   buf_load, buf_clear, consume, ack_accept;

  assign consume    = fetch_valid && !freeze;
  assign ack_accept = imem_req && imem_ack;

  // State, PC and outstanding-request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= '0;
      req_addr    <= '0;
      req_pending <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_addr    <= req_addr_next;
      req_pending <= req_pending_next;
    end
  end

  // Request generation, handshake bookkeeping, FSM and redirect handling.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    req_addr_next    = req_addr;
    req_pending_next = req_pending;
    buf_load         = 1'b0;
    buf_clear        = 1'b0;
    imem_req         = 1'b0;

    // An outstanding request keeps its original address until acked.
    imem_addr = req_pending ? req_addr : pc;

    // Reset gates the request so it drops immediately, not at the next edge.
    case (state)
      FETCH: imem_req = rst && (req_pending || !fetch_valid || consume);
      KILL:  imem_req = rst;
    endcase

    if (imem_req && !imem_ack) begin
      req_pending_next = 1'b1;
      req_addr_next    = imem_addr;
    end else if (ack_accept) begin
      req_pending_next = 1'b0;
    end

    case (state)
      FETCH: begin
        if (ack_accept) begin
          buf_load = 1'b1;
          pc_next  = pc + PC_INCR;
        end
      end
      KILL: begin
        if (ack_accept) state_next = FETCH;
      end
    endcase

    // A redirect overrides everything; a response still owed by memory
    // must be swallowed in KILL before the target can be requested.
    if (branch_taken) begin
      pc_next    = branch_address;
      buf_load   = 1'b0;
      buf_clear  = 1'b1;
      state_next = (imem_req && !imem_ack) ? KILL : FETCH;
    end
  end

  fetch_holding_buffer u_buffer (
    .clk             (clk),
    .rst             (rst),
    .load            (buf_load),
    .consume         (consume),
    .clear           (buf_clear),
    .load_instr      (imem_rdata),
    .load_pc         (pc + PC_INCR),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid           (fetch_valid)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  // Saturating count of cycles without a valid instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (!fetch_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases push the
// expected (pc_out, instruction_out) of every consumed instruction; a
// monitor pops and compares whenever the pipeline accepts a word.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
`endif

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
`ifdef FETCH_PERF_COUNTERS_EN
    .stall_cycles    (stall_cycles),
`endif
    .fetch_valid     (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Memory contents: address 0 holds a real ARM word, others are tagged.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A01001;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: ack after mem_lat waiting cycles, at most mem_budget acks.
  int mem_lat    = 0;
  int mem_budget = 0;
  int wait_cnt;
  int ack_count;

  always_comb begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    if (imem_req && (wait_cnt >= mem_lat) && (ack_count < mem_budget)) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 0;
      ack_count <= 0;
    end else begin
      if (imem_ack) ack_count <= ack_count + 1;
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && fetch_valid && !freeze) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got pc_out=%h instruction_out=%h expected none at %0t",
                   pc_out, instruction_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc_out", pc_out, e.pc);
          check("sb_instruction_out", instruction_out, e.instr);
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset two cycles, check cleared outputs, release at cycle c0 start.
  task automatic start_phase(input int lat, input int budget);
    rst            = 1'b0;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = '0;
    mem_lat        = lat;
    mem_budget     = budget;
    next_cycle();
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instruction_out", instruction_out, 32'h0);
    next_cycle();
    rst = 1'b1;
  endtask

  // Bounded wait for the scoreboard to empty, then idle to catch extras.
  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      next_cycle();
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) next_cycle();
  endtask

  initial begin
    int valid_cnt;
    rst            = 1'b0;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = '0;
    fork
      monitor_loop();
    join_none

    // Phase 1: zero-wait memory, then freeze for 2 cycles on address 8.
    start_phase(0, 5);
    push_exp(32'h4,  32'hE3A01001);
    push_exp(32'h8,  mem_word(32'h4));
    push_exp(32'hC,  mem_word(32'h8));
    push_exp(32'h10, mem_word(32'hC));
    push_exp(32'h14, mem_word(32'h10));
    @(negedge clk);
    check("p1_c0_req", {31'b0, imem_req}, 32'h1);
    check("p1_c0_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("p1_c0_stall_cycles", stall_cycles, 32'h0);
`endif
    repeat (3) next_cycle();
    freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("p1_freeze_instr", instruction_out, mem_word(32'h8));
      check("p1_freeze_pc", pc_out, 32'hC);
      check("p1_freeze_no_req", {31'b0, imem_req}, 32'h0);
      next_cycle();
    end
    freeze = 1'b0;
    @(negedge clk);
    check("p1_unfreeze_req", {31'b0, imem_req}, 32'h1);
    check("p1_unfreeze_addr", imem_addr, 32'hC);
    drain("p1");

    // Phase 2: 3-cycle latency, then reset in the middle of a request.
    start_phase(3, 4);
    push_exp(32'h4, 32'hE3A01001);
    push_exp(32'h8, mem_word(32'h4));
    push_exp(32'hC, mem_word(32'h8));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("p2_req_stable", {31'b0, imem_req}, 32'h1);
      check("p2_addr_stable", imem_addr, 32'h0);
      next_cycle();
    end
    valid_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fetch_valid) valid_cnt++;
      next_cycle();
    end
    check("p2_valid_1_in_4", valid_cnt, 32'd2);
    next_cycle();
    check("p2_pending_req", {31'b0, imem_req}, 32'h1);
    check("p2_pending_addr", imem_addr, 32'hC);
    #3;
    rst = 1'b0;
    #1;
    check("p2_async_rst_req", {31'b0, imem_req}, 32'h0);
    check("p2_async_rst_valid", {31'b0, fetch_valid}, 32'h0);
    check("p2_async_rst_pc", pc_out, 32'h0);
    check("p2_async_rst_instr", instruction_out, 32'h0);
    check("p2_queue_empty", exp_q.size(), 32'd0);

    // Phase 3: branch to 0x100 while the request to 0x20 is outstanding.
    start_phase(0, 8);
    for (int a = 0; a < 32; a += 4) push_exp(32'(a + 4), mem_word(32'(a)));
    push_exp(32'h104, mem_word(32'h100));
    repeat (9) next_cycle();
    branch_taken   = 1'b1;
    branch_address = 32'h100;
    @(negedge clk);
    check("p3_outstanding_req", {31'b0, imem_req}, 32'h1);
    check("p3_outstanding_addr", imem_addr, 32'h20);
    next_cycle();
    branch_taken = 1'b0;
    mem_budget   = 10;
    @(negedge clk);
    check("p3_kill_addr_held", imem_addr, 32'h20);
    check("p3_kill_req", {31'b0, imem_req}, 32'h1);
    check("p3_kill_no_valid", {31'b0, fetch_valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("p3_target_addr", imem_addr, 32'h100);
    check("p3_target_no_valid", {31'b0, fetch_valid}, 32'h0);
    drain("p3");

    // Phase 4: branch to 0x200 in the same cycle as an ack.
    start_phase(0, 3);
    push_exp(32'h4,   32'hE3A01001);
    push_exp(32'h204, mem_word(32'h200));
    next_cycle();
    branch_taken   = 1'b1;
    branch_address = 32'h200;
    @(negedge clk);
    check("p4_ack_cycle_addr", imem_addr, 32'h4);
    check("p4_ack_cycle_ack", {31'b0, imem_ack}, 32'h1);
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    check("p4_target_req", {31'b0, imem_req}, 32'h1);
    check("p4_target_addr", imem_addr, 32'h200);
    drain("p4");

    // Phase 5: redirect to 0xFFFFFFFC (via KILL), pc wraps to 0.
    start_phase(0, 0);
    push_exp(32'h0, mem_word(32'hFFFFFFFC));
    push_exp(32'h4, 32'hE3A01001);
    branch_taken   = 1'b1;
    branch_address = 32'hFFFFFFFC;
    @(negedge clk);
    check("p5_c0_addr", imem_addr, 32'h0);
    next_cycle();
    branch_taken = 1'b0;
    mem_budget   = 3;
    @(negedge clk);
    check("p5_kill_addr", imem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    check("p5_top_addr", imem_addr, 32'hFFFFFFFC);
    next_cycle();
    @(negedge clk);
    check("p5_wrap_addr", imem_addr, 32'h0);
    check("p5_wrap_pc_out", pc_out, 32'h0);
    check("p5_wrap_valid", {31'b0, fetch_valid}, 32'h1);
    drain("p5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
